// File: rtl/neopixel_chain_driver_if.sv
// Bundle of the frame-request handshake, frame-buffer read port and serial
// line of the NeoPixel chain driver.
// Optional macro NEOPIXEL_BRIGHTNESS_EN adds the 8-bit global brightness input.
interface neopixel_chain_driver_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              auto_repeat;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_rdata;
    logic              dout;
`ifdef NEOPIXEL_BRIGHTNESS_EN
    logic [7:0]        brightness;

    modport master (
        output start, auto_repeat, pix_rdata, brightness,
        input  busy, done, pix_addr, dout
    );

    modport slave (
        input  start, auto_repeat, pix_rdata, brightness,
        output busy, done, pix_addr, dout
    );
`else
    modport master (
        output start, auto_repeat, pix_rdata,
        input  busy, done, pix_addr, dout
    );

    modport slave (
        input  start, auto_repeat, pix_rdata,
        output busy, done, pix_addr, dout
    );
`endif
endinterface

// File: rtl/neopixel_chain_driver.sv
// WS2812 / NeoPixel chain driver: streams NUM_PIXELS 24-bit GRB words, fetched
// from an external frame buffer, as gapless bit cells of BIT_CYC clocks, then
// holds the line low for RESET_CYC clocks so the chain latches the frame.
// Optional macro NEOPIXEL_BRIGHTNESS_EN scales every colour channel by a global
// brightness value captured at the start of each frame.
module neopixel_chain_driver #(
    parameter int NUM_PIXELS = 12,
    parameter int ADDR_W     = 4,
    parameter int BIT_CYC    = 60,
    parameter int T0H_CYC    = 20,
    parameter int T1H_CYC    = 40,
    parameter int RESET_CYC  = 2880
) (
    input logic                   clk,
    input logic                   reset,
    neopixel_chain_driver_if.slave bus
);

    localparam int CELL_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int LAT_W  = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

    localparam logic [CELL_W-1:0] CELL_LAST = CELL_W'(BIT_CYC - 1);
    localparam logic [CELL_W-1:0] T0H_L     = CELL_W'(T0H_CYC);
    localparam logic [CELL_W-1:0] T1H_L     = CELL_W'(T1H_CYC);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RESET_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [4:0]        MSB_IDX   = 5'd23;

    // Reject timing sets that cannot produce a valid 0/1 distinction.
    generate
        if (!(T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && BIT_CYC >= 3 &&
              NUM_PIXELS >= 1 && RESET_CYC >= 1 &&
              (2 ** ADDR_W) >= NUM_PIXELS)) begin : g_param_check
            $error("neopixel_chain_driver: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t            state,      state_nx;
    logic [23:0]       shreg,      shreg_nx;
    logic [4:0]        bit_idx,    bit_idx_nx;
    logic [CELL_W-1:0] cell_cnt,   cell_cnt_nx;
    logic [ADDR_W-1:0] pix_idx,    pix_idx_nx;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_nx;
    logic [LAT_W-1:0]  lat_cnt,    lat_cnt_nx;
    logic              busy_q,     busy_nx;
    logic              done_q,     done_nx;

    logic [23:0]       load_word;

`ifdef NEOPIXEL_BRIGHTNESS_EN
    logic [7:0] bright_q;
    logic [7:0] bright_use;

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    // The LOAD cycle uses the live input so the very first pixel already sees
    // this frame's brightness; later pixels reuse the captured copy.
    assign bright_use = (state == LOAD) ? bus.brightness : bright_q;

    assign load_word = {scale_ch(bus.pix_rdata[23:16], bright_use),
                        scale_ch(bus.pix_rdata[15:8],  bright_use),
                        scale_ch(bus.pix_rdata[7:0],   bright_use)};

    // Capture brightness once per frame so it cannot change mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bright_q <= 8'd0;
        end else if (state == LOAD) begin
            bright_q <= bus.brightness;
        end
    end
`else
    assign load_word = bus.pix_rdata;
`endif

    // State and datapath registers; reset returns everything to a quiet IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            cell_cnt   <= '0;
            pix_idx    <= '0;
            pix_addr_q <= '0;
            lat_cnt    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            shreg      <= shreg_nx;
            bit_idx    <= bit_idx_nx;
            cell_cnt   <= cell_cnt_nx;
            pix_idx    <= pix_idx_nx;
            pix_addr_q <= pix_addr_nx;
            lat_cnt    <= lat_cnt_nx;
            busy_q     <= busy_nx;
            done_q     <= done_nx;
        end
    end

    // Next-state logic: frame sequencing, bit-cell timing and address prefetch.
    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        bit_idx_nx  = bit_idx;
        cell_cnt_nx = cell_cnt;
        pix_idx_nx  = pix_idx;
        pix_addr_nx = pix_addr_q;
        lat_cnt_nx  = lat_cnt;
        busy_nx     = busy_q;
        done_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx    = LOAD;
                    pix_addr_nx = '0;
                    busy_nx     = 1'b1;
                end
            end

            LOAD: begin
                shreg_nx    = load_word;
                bit_idx_nx  = MSB_IDX;
                cell_cnt_nx = '0;
                pix_idx_nx  = '0;
                state_nx    = SEND;
            end

            SEND: begin
                // Fetch the next pixel a whole bit cell ahead of the boundary,
                // leaving the buffer's read latency plenty of slack.
                if (bit_idx == 5'd0 && cell_cnt == '0 && pix_idx != LAST_PIX) begin
                    pix_addr_nx = pix_idx + ADDR_W'(1);
                end
                if (cell_cnt == CELL_LAST) begin
                    cell_cnt_nx = '0;
                    if (bit_idx == 5'd0) begin
                        if (pix_idx == LAST_PIX) begin
                            state_nx   = LATCH;
                            lat_cnt_nx = '0;
                        end else begin
                            shreg_nx   = load_word;
                            pix_idx_nx = pix_idx + ADDR_W'(1);
                            bit_idx_nx = MSB_IDX;
                        end
                    end else begin
                        bit_idx_nx = bit_idx - 5'd1;
                        shreg_nx   = {shreg[22:0], 1'b0};
                    end
                end else begin
                    cell_cnt_nx = cell_cnt + CELL_W'(1);
                end
            end

            LATCH: begin
                if (lat_cnt == LAT_LAST) begin
                    done_nx = 1'b1;
                    if (bus.auto_repeat) begin
                        pix_addr_nx = '0;
                        state_nx    = LOAD;
                    end else begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                    end
                end else begin
                    lat_cnt_nx = lat_cnt + LAT_W'(1);
                end
            end

            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // The line is driven purely from registers, so an asynchronous reset
    // pulls it low at once; the shift register MSB is the bit on the wire.
    assign bus.dout     = (state == SEND) && (cell_cnt < (shreg[23] ? T1H_L : T0H_L));
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pix_addr = pix_addr_q;

endmodule

// File: tb/tb_neopixel_chain_driver.sv
// Directed bench for neopixel_chain_driver: decodes the serial line back into
// pixel words and checks frame timing, handshakes, prefetch and reset.
// Optional macro NEOPIXEL_BRIGHTNESS_EN adds a brightness-scaled frame.
module tb_neopixel_chain_driver;

    localparam int NUM_PIXELS = 12;
    localparam int ADDR_W     = 4;
    localparam int BIT_CYC    = 60;
    localparam int T0H_CYC    = 20;
    localparam int T1H_CYC    = 40;
    localparam int RESET_CYC  = 2880;
    localparam int NCELLS     = NUM_PIXELS * 24;
    localparam int FRAME_CYC  = NUM_PIXELS * 24 * BIT_CYC + RESET_CYC;
    localparam int PIX_CYC    = 24 * BIT_CYC;

    logic clk = 1'b0;
    logic reset;

    // Free-running 100 MHz-style bench clock.
    always #5 clk = ~clk;

    neopixel_chain_driver_if #(.ADDR_W(ADDR_W)) bus ();

    logic [23:0] fb [0:(1<<ADDR_W)-1];
    assign bus.pix_rdata = fb[bus.pix_addr];

    neopixel_chain_driver #(
        .NUM_PIXELS (NUM_PIXELS),
        .ADDR_W     (ADDR_W),
        .BIT_CYC    (BIT_CYC),
        .T0H_CYC    (T0H_CYC),
        .T1H_CYC    (T1H_CYC),
        .RESET_CYC  (RESET_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int clear_req  = 0;
    int clear_seen = 0;
    int cyc = 0;
    logic prev_dout = 1'b0;
    int high_cnt, since_rise, cell_n, bad_period, bad_high, done_cnt, busy_low, addr_n;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic cells [0:NCELLS-1];
    int addr_t [0:15];
    logic [ADDR_W-1:0] addr_v [0:15];

    // Line monitor: measures each cell's high time and rise-to-rise period,
    // decodes bits, and logs done pulses, busy drops and address changes.
    always @(negedge clk) begin
        cyc++;
        if (clear_req != clear_seen) begin
            clear_seen = clear_req;
            prev_dout  = 1'b0;
            high_cnt   = 0;
            since_rise = 0;
            cell_n     = 0;
            bad_period = 0;
            bad_high   = 0;
            done_cnt   = 0;
            busy_low   = 0;
            addr_n     = 0;
            prev_addr  = bus.pix_addr;
        end
        since_rise++;
        if (bus.dout === 1'b1 && prev_dout !== 1'b1) begin
            if (cell_n > 0 && since_rise != BIT_CYC) bad_period++;
            since_rise = 0;
            high_cnt   = 1;
        end else if (bus.dout === 1'b1) begin
            high_cnt++;
        end
        if (bus.dout !== 1'b1 && prev_dout === 1'b1) begin
            if (high_cnt != T1H_CYC && high_cnt != T0H_CYC) bad_high++;
            if (cell_n < NCELLS) cells[cell_n] = (high_cnt == T1H_CYC);
            cell_n++;
        end
        prev_dout = bus.dout;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.busy !== 1'b1) busy_low++;
        if (bus.pix_addr !== prev_addr) begin
            if (addr_n < 16) begin
                addr_t[addr_n] = cyc;
                addr_v[addr_n] = bus.pix_addr;
            end
            addr_n++;
            prev_addr = bus.pix_addr;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic ar);
        bus.start       = s;
        bus.auto_repeat = ar;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [23:0] cellWord(input int p);
        logic [23:0] w;
        w = '0;
        for (int j = 0; j < 24; j++) w = {w[22:0], cells[p*24 + j]};
        return w;
    endfunction

    task automatic checkFrameCells(input string tag);
        checkOutput({tag, "_cells"}, 32'(cell_n), 32'(NCELLS));
        checkOutput({tag, "_bad_period"}, 32'(bad_period), 32'd0);
        checkOutput({tag, "_bad_high"}, 32'(bad_high), 32'd0);
        for (int p = 0; p < NUM_PIXELS; p++) begin
            checkOutput($sformatf("%s_pix%0d", tag, p), 32'(cellWord(p)), 32'(fb[p]));
        end
    endtask

    // Hard stop in case a wait is somehow never bounded.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence: reset, pattern frame with ignored start, reset
    // mid-frame, then an auto-repeat pair of frames.
    initial begin
        int t_ref;
        int t_done1;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
`ifdef NEOPIXEL_BRIGHTNESS_EN
        bus.brightness = 8'd255;
`endif
        for (int i = 0; i < (1 << ADDR_W); i++) fb[i] = 24'(24'h010203 * i);
        repeat (3) tick();

        checkOutput("rst_dout", 32'(bus.dout), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_addr", 32'(bus.pix_addr), 32'd0);

        reset = 1'b0;
        repeat (2) tick();

        // Frame A: 12-pixel pattern, a stray start 500 cycles in.
        clear_req++;
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("A_load_busy", 32'(bus.busy), 32'd1);
        checkOutput("A_load_dout", 32'(bus.dout), 32'd0);
        checkOutput("A_load_addr", 32'(bus.pix_addr), 32'd0);
        applyStimulus(1'b0, 1'b0);
        tick();
        t_ref = cyc;
        checkOutput("A_first_rise", 32'(bus.dout), 32'd1);
        repeat (499) tick();
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        waitDone(25000);
        checkOutput("A_frame_len", 32'(cyc - t_ref), 32'(FRAME_CYC));
        checkOutput("A_busy_with_done", 32'(bus.busy), 32'd0);
        tick();
        checkOutput("A_done_pulse_end", 32'(bus.done), 32'd0);
        checkOutput("A_done_count", 32'(done_cnt), 32'd1);
        checkFrameCells("A");
        // Address k+1 is requested at the end of the first cycle of bit 0 of
        // pixel k, i.e. 23 cells plus one cycle after that pixel starts.
        checkOutput("A_addr_steps", 32'(addr_n), 32'(NUM_PIXELS - 1));
        for (int k = 0; k < NUM_PIXELS - 1; k++) begin
            checkOutput($sformatf("A_addr%0d_val", k), 32'(addr_v[k]), 32'(k + 1));
            checkOutput($sformatf("A_addr%0d_time", k), 32'(addr_t[k] - t_ref),
                        32'(23 * BIT_CYC + 1 + k * PIX_CYC));
        end

        // Frame B: asynchronous reset while the line is high.
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        tick();
        repeat (3000) tick();
        checkOutput("B_pre_reset_dout", 32'(bus.dout), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("B_async_dout", 32'(bus.dout), 32'd0);
        checkOutput("B_async_busy", 32'(bus.busy), 32'd0);
        checkOutput("B_async_addr", 32'(bus.pix_addr), 32'd0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Frames C and D: auto-repeat, first pixels carry edge-case words.
        fb[0] = 24'h800001;
        fb[1] = 24'hFF8001;
        clear_req++;
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        t_ref = cyc;
        checkOutput("C_first_rise", 32'(bus.dout), 32'd1);
        waitDone(25000);
        t_done1 = cyc;
        checkOutput("C_frame_len", 32'(cyc - t_ref), 32'(FRAME_CYC));
        checkOutput("C_busy_held", 32'(bus.busy), 32'd1);
        checkOutput("C_busy_never_low", 32'(busy_low), 32'd0);
        checkOutput("C_done_count", 32'(done_cnt), 32'd1);
        checkFrameCells("C");
        // The done cycle is already the LOAD cycle of the repeated frame.
        checkOutput("D_load_addr", 32'(bus.pix_addr), 32'd0);
        checkOutput("D_load_dout", 32'(bus.dout), 32'd0);
        clear_req++;
        tick();
        checkOutput("D_first_rise", 32'(bus.dout), 32'd1);
        repeat (100) tick();
        applyStimulus(1'b0, 1'b0);
        waitDone(25000);
        checkOutput("D_done_to_done", 32'(cyc - t_done1), 32'(FRAME_CYC + 1));
        checkOutput("D_busy_with_done", 32'(bus.busy), 32'd0);
        checkOutput("D_busy_low_only_at_end", 32'(busy_low), 32'd1);
        checkFrameCells("D");
        tick();
        checkOutput("D_done_pulse_end", 32'(bus.done), 32'd0);
        checkOutput("D_stays_idle", 32'(bus.busy), 32'd0);

`ifdef NEOPIXEL_BRIGHTNESS_EN
        // Frame E: brightness 127 halves each channel (c*128 >> 8).
        bus.brightness = 8'd127;
        clear_req++;
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        waitDone(25000);
        checkOutput("E_cells", 32'(cell_n), 32'(NCELLS));
        checkOutput("E_pix0", 32'(cellWord(0)), 32'h400000);
        checkOutput("E_pix1", 32'(cellWord(1)), 32'h7F4000);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
